clk_divider_multi: RTL and testbench

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

---
 rtl/clk_divider_multi.sv | 85 ++++++++
 tb/tb_clk_divider_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel integer clock divider: per-channel counter, shadowed divisor applied
// only at a period boundary (or immediately while the channel is idle).
module clk_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              div_load,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_shd;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] deff;
        logic [CNT_W-1:0] half;
        logic             wrap;
        logic             load_hit;
        logic             clk_r;
        logic             tick_r;
        logic             pend_r;

        // Divisors below 2 behave as 2; the high phase takes the extra cycle for odd divisors.
        always_comb begin
            deff     = (div_act < CNT_W'(2)) ? CNT_W'(2) : div_act;
            half     = deff - (deff >> 1);
            wrap     = (cnt == deff - CNT_W'(1));
            load_hit = div_load && (div_ch == CH_W'(i));
        end

        always_ff @(posedge clk_in) begin
            if (!rst) begin
                div_act <= CNT_W'(DEFAULT_DIV);
                div_shd <= CNT_W'(DEFAULT_DIV);
                cnt     <= '0;
                clk_r   <= 1'b0;
                tick_r  <= 1'b0;
                pend_r  <= 1'b0;
            end else begin
                if (load_hit) begin
                    div_shd <= div_val;
                end
                if (!ch_en[i]) begin
                    cnt    <= '0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                    if (pend_r) begin
                        div_act <= div_shd;
                    end
                    pend_r <= load_hit;
                end else begin
                    // Outputs reflect the current count, so cnt==0 yields the rising edge and tick.
                    clk_r  <= (cnt < half);
                    tick_r <= (cnt == '0);
                    if (wrap) begin
                        cnt <= '0;
                        if (pend_r) begin
                            div_act <= div_shd;
                        end
                        pend_r <= load_hit;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (load_hit) begin
                            pend_r <= 1'b1;
                        end
                    end
                end
            end
        end

        assign clk_out[i]     = clk_r;
        assign tick[i]        = tick_r;
        assign div_pending[i] = pend_r;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: vector table, hand sequences for divisor
// update corner cases, and random stimulus against a per-period waveform queue model.
module tb_clk_divider_multi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    logic              clk_in = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              div_load;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_val;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_pending;

    always #5 clk_in = ~clk_in;

    clk_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
        .clk_in(clk_in), .rst(rst), .ch_en(ch_en), .div_load(div_load),
        .div_ch(div_ch), .div_val(div_val), .clk_out(clk_out), .tick(tick),
        .div_pending(div_pending)
    );

    int checks = 0;
    int errors = 0;

    // Reference: active/shadow divisor and a queue holding the rest of the current period's waveform.
    int md[NUM_CH];
    int ms[NUM_CH];
    bit mp[NUM_CH];
    bit mq[NUM_CH][$];
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;

    typedef struct {
        logic [3:0]  en;
        logic        ld;
        logic [1:0]  ch;
        logic [15:0] val;
        logic [3:0]  x_clk;
        logic [3:0]  x_tick;
        logic [3:0]  x_pend;
    } vec_t;
    vec_t vt[13];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic cyc();
        logic              rst_s = rst;
        logic [NUM_CH-1:0] en_s  = ch_en;
        logic              ld_s  = div_load;
        logic [CH_W-1:0]   ch_s  = div_ch;
        logic [CNT_W-1:0]  val_s = div_val;
        @(posedge clk_in);
        for (int c = 0; c < NUM_CH; c++) begin
            e_clk[c]  = 1'b0;
            e_tick[c] = 1'b0;
            if (!rst_s) begin
                mq[c].delete();
                md[c] = 4;
                ms[c] = 4;
                mp[c] = 1'b0;
            end else begin
                if (en_s[c]) begin
                    if (mq[c].size() == 0) begin
                        int deff = (md[c] < 2) ? 2 : md[c];
                        for (int k = 0; k < deff; k++) mq[c].push_back(k < deff - deff / 2);
                        e_tick[c] = 1'b1;
                    end
                    e_clk[c] = mq[c].pop_front();
                    if (mq[c].size() == 0 && mp[c]) begin
                        md[c] = ms[c];
                        mp[c] = 1'b0;
                    end
                end else begin
                    mq[c].delete();
                    if (mp[c]) begin
                        md[c] = ms[c];
                        mp[c] = 1'b0;
                    end
                end
                if (ld_s && int'(ch_s) == c) begin
                    ms[c] = int'(val_s);
                    mp[c] = 1'b1;
                end
            end
            e_pend[c] = mp[c];
        end
        #1;
        check("clk_out", 32'(clk_out), 32'(e_clk));
        check("tick", 32'(tick), 32'(e_tick));
        check("div_pending", 32'(div_pending), 32'(e_pend));
    endtask

    task automatic load(int c, int val);
        div_load = 1'b1;
        div_ch   = CH_W'(c);
        div_val  = CNT_W'(val);
        cyc();
        div_load = 1'b0;
    endtask

    task automatic wait_tick(int c, int bound);
        int n = 0;
        while (!tick[c] && n < bound) begin
            cyc();
            n++;
        end
        check($sformatf("tick_seen_ch%0d", c), 32'(tick[c]), 32'd1);
    endtask

    task automatic wait_pend_clear(int c, int bound);
        int n = 0;
        while (div_pending[c] && n < bound) begin
            cyc();
            n++;
        end
        check($sformatf("pend_clear_ch%0d", c), 32'(div_pending[c]), 32'd0);
    endtask

    task automatic measure(int c, int bound, output int per, output int hi);
        wait_tick(c, bound);
        per = 0;
        hi  = 0;
        do begin
            hi += int'(clk_out[c]);
            per++;
            cyc();
        end while (!tick[c] && per < bound);
    endtask

    initial begin
        int per, hi, n;
        logic [3:0] pat_clk;
        logic [3:0] pat_tick;

        rst = 1'b0; ch_en = 4'hF; div_load = 1'b0; div_ch = '0; div_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            md[c] = 4; ms[c] = 4; mp[c] = 1'b0;
        end

        vt[0]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF, 4'h0};
        vt[1]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0};
        vt[2]  = '{4'hF, 1'b1, 2'd1, 16'd5, 4'h0, 4'h0, 4'h2};
        vt[3]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h0};
        vt[4]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hF, 4'hF, 4'h0};
        vt[5]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0};
        vt[6]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h2, 4'h0, 4'h0};
        vt[7]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h0, 4'h0, 4'h0};
        vt[8]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hD, 4'hD, 4'h0};
        vt[9]  = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hF, 4'h2, 4'h0};
        vt[10] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h2, 4'h0, 4'h0};
        vt[11] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'h2, 4'h0, 4'h0};
        vt[12] = '{4'hF, 1'b0, 2'd0, 16'd0, 4'hD, 4'hD, 4'h0};

        cyc();
        cyc();
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_pending", 32'(div_pending), 32'd0);
        rst = 1'b1;

        // Default divide-by-4 from reset release, then a mid-period load of 5 on ch1.
        for (int i = 0; i < 13; i++) begin
            ch_en = vt[i].en; div_load = vt[i].ld; div_ch = vt[i].ch; div_val = vt[i].val;
            cyc();
            check($sformatf("vec%0d_clk", i), 32'(clk_out), 32'(vt[i].x_clk));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vt[i].x_tick));
            check($sformatf("vec%0d_pend", i), 32'(div_pending), 32'(vt[i].x_pend));
        end
        div_load = 1'b0;

        // Divisors 0 and 1 collapse to 2; 0xFFFF gives the longest period.
        load(3, 0);
        wait_pend_clear(3, 20);
        measure(3, 20, per, hi);
        check("div0_period", 32'(per), 32'd2);
        check("div0_high", 32'(hi), 32'd1);
        load(3, 1);
        wait_pend_clear(3, 20);
        measure(3, 20, per, hi);
        check("div1_period", 32'(per), 32'd2);
        check("div1_high", 32'(hi), 32'd1);
        load(3, 16'hFFFF);
        wait_pend_clear(3, 20);
        measure(3, 70000, per, hi);
        check("divmax_period", 32'(per), 32'd65535);
        check("divmax_high", 32'(hi), 32'd32768);
        load(3, 4);
        ch_en[3] = 1'b0;
        cyc();
        check("disable_applies_ch3", 32'(div_pending[3]), 32'd0);
        ch_en[3] = 1'b1;

        // Back-to-back loads: only the last one takes effect.
        wait_tick(2, 20);
        load(2, 6);
        load(2, 8);
        check("double_load_pend", 32'(div_pending[2]), 32'd1);
        wait_pend_clear(2, 20);
        measure(2, 20, per, hi);
        check("double_load_period", 32'(per), 32'd8);
        check("double_load_high", 32'(hi), 32'd4);

        // Load landing on the wrap: older shadow applies first, new one stays pending.
        load(2, 3);
        n = 0;
        while (mq[2].size() != 1 && n < 50) begin
            cyc();
            n++;
        end
        check("wrap_found", 32'(mq[2].size()), 32'd1);
        load(2, 5);
        check("wrap_load_pend", 32'(div_pending[2]), 32'd1);
        measure(2, 20, per, hi);
        check("wrap_first_period", 32'(per), 32'd3);
        check("wrap_first_high", 32'(hi), 32'd2);
        measure(2, 20, per, hi);
        check("wrap_second_period", 32'(per), 32'd5);
        check("wrap_second_high", 32'(hi), 32'd3);

        // Disable ch0 while high, load 3 while idle, re-enable.
        wait_tick(0, 20);
        ch_en[0] = 1'b0;
        cyc();
        check("dis_clk0", 32'(clk_out[0]), 32'd0);
        check("dis_tick0", 32'(tick[0]), 32'd0);
        load(0, 3);
        check("dis_load_pend0", 32'(div_pending[0]), 32'd1);
        cyc();
        check("dis_apply_pend0", 32'(div_pending[0]), 32'd0);
        check("dis_clk0_idle", 32'(clk_out[0]), 32'd0);
        ch_en[0] = 1'b1;
        pat_clk  = 4'b1101;
        pat_tick = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("restart_clk0_%0d", i), 32'(clk_out[0]), 32'(pat_clk[3-i]));
            check($sformatf("restart_tick0_%0d", i), 32'(tick[0]), 32'(pat_tick[3-i]));
        end

        // One-cycle reset with a divisor pending discards it and restores divide-by-4.
        wait_tick(1, 20);
        load(1, 7);
        check("pre_reset_pend1", 32'(div_pending[1]), 32'd1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("post_reset_pend", 32'(div_pending), 32'd0);
        check("post_reset_clk", 32'(clk_out), 32'd0);
        for (int c = 0; c < NUM_CH; c++) begin
            measure(c, 20, per, hi);
            check($sformatf("post_reset_period_ch%0d", c), 32'(per), 32'd4);
            check($sformatf("post_reset_high_ch%0d", c), 32'(hi), 32'd2);
        end

        // Random enables and loads against the model.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
            div_load = ($urandom_range(0, 3) == 0);
            div_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
            div_val  = CNT_W'($urandom_range(0, 9));
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
            cyc();
            rst = 1'b1;
        end
        div_load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
